// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of client-side and I2C-master-side signals around the two-client bus arbiter.
// The master modport is the arbiter's view; slave is the surrounding clients plus master.
interface i2c_bus_arbiter_if;
    logic       req0, req1, gnt0, gnt1;
    logic       start0, start1, send0, send1, receive0, receive1;
    logic [7:0] datasend0, datasend1;
    logic       isReady0, isReady1, sended0, sended1, received0, received1;
    logic [7:0] datareceive_c;
    logic       start, send, receive;
    logic [7:0] datasend;
    logic       isReady, sended, received;
    logic [7:0] datareceive;
    logic       busy, timeoutErr, errOwner;

    modport master (
        input  req0, req1, start0, start1, send0, send1, receive0, receive1,
        input  datasend0, datasend1, isReady, sended, received, datareceive,
        output gnt0, gnt1, isReady0, isReady1, sended0, sended1, received0, received1,
        output datareceive_c, start, send, receive, datasend, busy, timeoutErr, errOwner
    );

    modport slave (
        output req0, req1, start0, start1, send0, send1, receive0, receive1,
        output datasend0, datasend1, isReady, sended, received, datareceive,
        input  gnt0, gnt1, isReady0, isReady1, sended0, sended1, received0, received1,
        input  datareceive_c, start, send, receive, datasend, busy, timeoutErr, errOwner
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin sharing of one I2C byte master between two transaction-holding clients.
// Latency: grant one cycle after a sampled request; two no-grant cycles between owners.
// Backpressure: owner holds the bus until it drops req and the master is ready, or a busy timeout fires.
module i2c_bus_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input logic               clk,
    input logic               reset,
    i2c_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN, GAP} state_t;

    state_t      st, stNext;
    logic        owner, ownerNext;
    logic        last, lastNext;
    logic [15:0] cnt;
    logic        timeoutErrQ, errOwnerQ;
    logic        active, reqOwner, timeoutHit, enterGrant;

    assign active     = (st == GRANT) || (st == DRAIN);
    assign reqOwner   = owner ? bus.req1 : bus.req0;
    assign timeoutHit = active && (cnt == TIMEOUT - 16'd1);
    assign enterGrant = (st == IDLE) && (stNext == GRANT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st    <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            st    <= stNext;
            owner <= ownerNext;
            last  <= lastNext;
        end
    end

    always_comb begin
        stNext    = st;
        ownerNext = owner;
        lastNext  = last;
        case (st)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    stNext    = GRANT;
                    ownerNext = ~last;
                end else if (bus.req0) begin
                    stNext    = GRANT;
                    ownerNext = 1'b0;
                end else if (bus.req1) begin
                    stNext    = GRANT;
                    ownerNext = 1'b1;
                end
            end
            GRANT: begin
                if (!reqOwner) begin
                    if (bus.isReady) begin
                        stNext   = GAP;
                        lastNext = owner;
                    end else begin
                        stNext = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Never cut the master mid-frame: release only once it reports ready.
                if (bus.isReady) begin
                    stNext   = GAP;
                    lastNext = owner;
                end
            end
            default: stNext = IDLE;
        endcase
        if (timeoutHit) begin
            stNext   = GAP;
            lastNext = owner;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= 16'd0;
            timeoutErrQ <= 1'b0;
            errOwnerQ   <= 1'b0;
        end else begin
            if (enterGrant || timeoutHit || bus.isReady) begin
                cnt <= 16'd0;
            end else if (active) begin
                cnt <= cnt + 16'd1;
            end
            timeoutErrQ <= timeoutHit;
            if (timeoutHit) begin
                errOwnerQ <= owner;
            end
        end
    end

    always_comb begin
        bus.gnt0          = active && !owner;
        bus.gnt1          = active && owner;
        bus.busy          = active;
        bus.start         = 1'b0;
        bus.send          = 1'b0;
        bus.receive       = 1'b0;
        bus.datasend      = 8'h00;
        if (active) begin
            bus.receive  = owner ? bus.receive1 : bus.receive0;
            bus.datasend = owner ? bus.datasend1 : bus.datasend0;
        end
        // Draining owner may finish a read but cannot open a new frame.
        if (st == GRANT) begin
            bus.start = owner ? bus.start1 : bus.start0;
            bus.send  = owner ? bus.send1 : bus.send0;
        end
        bus.isReady0      = bus.isReady && active && !owner;
        bus.isReady1      = bus.isReady && active && owner;
        bus.sended0       = bus.sended && active && !owner;
        bus.sended1       = bus.sended && active && owner;
        bus.received0     = bus.received && active && !owner;
        bus.received1     = bus.received && active && owner;
        bus.datareceive_c = bus.datareceive;
        bus.timeoutErr    = timeoutErrQ;
        bus.errOwner      = errOwnerQ;
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_i2c_bus_arbiter;
    localparam int TO = 20;

    logic clk;
    logic reset;
    i2c_bus_arbiter_if bus();

    i2c_bus_arbiter #(.TIMEOUT(16'd20)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nComp = 0;
    int nFail = 0;

    // Model: who holds the bus (-1 none), whether it is draining, cooldown before arbitration resumes.
    int holder;
    bit draining;
    int cooldown;
    int busyRun;
    int lastServed;
    bit expErr;
    bit expErrOwner;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expired(input string tag);
        nComp++;
        nFail++;
        $error("FAIL %s wait expired observed=0 expected=1", tag);
    endtask

    task automatic modelReset();
        holder = -1; draining = 0; cooldown = 0; busyRun = 0;
        lastServed = 1; expErr = 0; expErrOwner = 0;
    endtask

    task automatic releaseBus();
        lastServed = holder;
        holder     = -1;
        cooldown   = 1;
    endtask

    task automatic modelStep();
        bit reqHeld;
        expErr = 0;
        if (holder < 0) begin
            if (cooldown > 0) cooldown--;
            else if (bus.req0 || bus.req1) begin
                if (bus.req0 && bus.req1) holder = (lastServed == 0) ? 1 : 0;
                else holder = bus.req0 ? 0 : 1;
                draining = 0;
                busyRun  = 0;
            end
        end else if (busyRun == TO - 1) begin
            expErr      = 1;
            expErrOwner = (holder == 1);
            releaseBus();
        end else begin
            reqHeld = (holder == 0) ? bus.req0 : bus.req1;
            busyRun = bus.isReady ? 0 : busyRun + 1;
            if (!reqHeld || draining) begin
                if (bus.isReady) releaseBus();
                else draining = 1;
            end
        end
    endtask

    task automatic checkAll();
        bit own, ctl, frm;
        logic [2:0] expCtl;
        logic [7:0] expDs;
        own = (holder == 1);
        ctl = (holder >= 0);
        frm = ctl && !draining;
        expCtl = {frm && (own ? bus.start1 : bus.start0),
                  frm && (own ? bus.send1 : bus.send0),
                  ctl && (own ? bus.receive1 : bus.receive0)};
        expDs = ctl ? (own ? bus.datasend1 : bus.datasend0) : 8'h00;
        chk("gnt", 16'({bus.gnt1, bus.gnt0}), 16'({holder == 1, holder == 0}));
        chk("busy", 16'(bus.busy), 16'(ctl));
        chk("ctl", 16'({bus.start, bus.send, bus.receive}), 16'(expCtl));
        chk("datasend", 16'(bus.datasend), 16'(expDs));
        chk("ret", 16'({bus.isReady1, bus.isReady0, bus.sended1, bus.sended0, bus.received1, bus.received0}),
            16'({bus.isReady && holder == 1, bus.isReady && holder == 0,
                 bus.sended && holder == 1, bus.sended && holder == 0,
                 bus.received && holder == 1, bus.received && holder == 0}));
        chk("datareceive_c", 16'(bus.datareceive_c), 16'(bus.datareceive));
        chk("timeoutErr", 16'(bus.timeoutErr), 16'(expErr));
        chk("errOwner", 16'(bus.errOwner), 16'(expErrOwner));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) modelReset();
        else modelStep();
        #1;
        checkAll();
    endtask

    // which: 0 -> gnt0, 1 -> gnt1, 2 -> bus idle
    task automatic waitFor(input int which, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = (which == 0) ? bus.gnt0 : (which == 1) ? bus.gnt1 : !bus.busy;
        end
        if (!ok) expired(tag);
    endtask

    task automatic randomizeCtl();
        bus.start0 = 1'($urandom); bus.start1 = 1'($urandom);
        bus.send0 = 1'($urandom); bus.send1 = 1'($urandom);
        bus.receive0 = 1'($urandom); bus.receive1 = 1'($urandom);
        bus.datasend0 = 8'($urandom); bus.datasend1 = 8'($urandom);
        bus.sended = 1'($urandom); bus.received = 1'($urandom);
        bus.datareceive = 8'($urandom);
    endtask

    initial begin
        int order[$];
        int gaps[$];
        int idleRun, sinceGnt0, sinceGnt1, n, stall;
        logic [1:0] g, prevG;
        bit found;

        modelReset();
        reset = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.isReady = 1;
        bus.start0 = 0; bus.start1 = 0; bus.send0 = 0; bus.send1 = 0;
        bus.receive0 = 0; bus.receive1 = 0; bus.datasend0 = 0; bus.datasend1 = 0;
        bus.sended = 0; bus.received = 0; bus.datareceive = 0;

        // Reset held: everything toggling, outputs must stay at reset values.
        for (int i = 0; i < 6; i++) begin
            bus.req0 = 1'($urandom); bus.req1 = 1'($urandom);
            bus.isReady = 1'($urandom);
            randomizeCtl();
            tick();
        end
        reset = 1'b1;
        bus.isReady = 1; bus.sended = 0; bus.received = 0;
        bus.start0 = 0; bus.start1 = 0; bus.send0 = 0; bus.send1 = 0;

        // Round-robin tie: each client drops 10 cycles after its grant, then re-requests.
        bus.req0 = 1; bus.req1 = 1;
        idleRun = 0; sinceGnt0 = 0; sinceGnt1 = 0; prevG = 2'b00;
        for (int c = 0; c < 150 && order.size() < 5; c++) begin
            tick();
            g = {bus.gnt1, bus.gnt0};
            if (g != 2'b00 && prevG == 2'b00) begin
                order.push_back(g[1] ? 1 : 0);
                gaps.push_back(idleRun);
            end
            idleRun = (g == 2'b00) ? idleRun + 1 : 0;
            if (g[0]) begin
                sinceGnt0 = prevG[0] ? sinceGnt0 + 1 : 1;
                if (sinceGnt0 == 10) bus.req0 = 0;
            end else if (!bus.req0) bus.req0 = 1;
            if (g[1]) begin
                sinceGnt1 = prevG[1] ? sinceGnt1 + 1 : 1;
                if (sinceGnt1 == 10) bus.req1 = 0;
            end else if (!bus.req1) bus.req1 = 1;
            prevG = g;
        end
        if (order.size() < 5) expired("rr_grants");
        else begin
            for (int i = 0; i < 4; i++) chk("rr_order", 16'(order[i]), 16'(i % 2));
            for (int i = 1; i < 4; i++) chk("rr_gap", 16'(gaps[i]), 16'd2);
        end
        bus.req0 = 0; bus.req1 = 0;
        waitFor(2, "rr_idle");
        tick(); tick();

        // Mux isolation: client 0 owns, client 1 drives conflicting values.
        bus.req0 = 1;
        waitFor(0, "mux_gnt0");
        bus.datasend0 = 8'hEE; bus.datasend1 = 8'h5A; bus.start1 = 1; bus.start0 = 0;
        bus.sended = 1; bus.received = 1;
        tick();
        chk("mux_datasend", 16'(bus.datasend), 16'h00EE);
        chk("mux_start_lo", 16'(bus.start), 16'd0);
        chk("mux_sended1", 16'({bus.sended1, bus.received1}), 16'd0);
        chk("mux_sended0", 16'(bus.sended0), 16'd1);
        bus.start0 = 1; bus.sended = 0;
        tick();
        chk("mux_start_hi", 16'(bus.start), 16'd1);
        chk("mux_sended_pulse", 16'({bus.sended1, bus.sended0}), 16'd0);

        // Drain: owner leaves while the master is still busy for 5 more cycles.
        bus.req1 = 1; bus.send0 = 1; bus.isReady = 0;
        tick();
        bus.req0 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drain_gnt0", 16'(bus.gnt0), 16'd1);
            chk("drain_start_send", 16'({bus.start, bus.send}), 16'd0);
        end
        bus.isReady = 1;
        tick();
        chk("drain_release", 16'({bus.gnt1, bus.gnt0}), 16'd0);
        tick();
        chk("drain_gap2", 16'({bus.gnt1, bus.gnt0}), 16'd0);
        tick();
        chk("drain_next_gnt1", 16'(bus.gnt1), 16'd1);

        // Timeout: client 1 owns, master stuck busy.
        bus.isReady = 0;
        n = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            n++;
            found = bus.timeoutErr;
        end
        if (!found) expired("to_pulse");
        else begin
            chk("to_cycles", 16'(n), 16'(TO));
            chk("to_errOwner", 16'(bus.errOwner), 16'd1);
            chk("to_gnt1_drop", 16'(bus.gnt1), 16'd0);
        end
        tick();
        chk("to_pulse_width", 16'(bus.timeoutErr), 16'd0);
        bus.isReady = 1; bus.req1 = 0;
        waitFor(2, "to_idle");

        // Asynchronous reset while client 0 is in GRANT.
        bus.req0 = 1; bus.req1 = 1; bus.start0 = 1; bus.send0 = 0;
        waitFor(0, "arst_gnt0");
        #3 reset = 1'b0;
        #1;
        chk("arst_gnt0", 16'({bus.gnt0, bus.busy}), 16'd0);
        chk("arst_start", 16'(bus.start), 16'd0);
        modelReset();
        #2 reset = 1'b1;
        waitFor(0, "arst_regrant0");
        chk("arst_regrant_not1", 16'(bus.gnt1), 16'd0);

        // Random traffic with occasional long master stalls.
        stall = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 15) == 0) bus.req1 = ~bus.req1;
            if (stall > 0) begin
                stall--;
                bus.isReady = 0;
            end else if ($urandom_range(0, 99) == 0) begin
                stall = 25;
                bus.isReady = 0;
            end else if (bus.isReady) bus.isReady = ($urandom_range(0, 7) != 0);
            else bus.isReady = ($urandom_range(0, 3) == 0);
            randomizeCtl();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end
endmodule
